// File: rtl/ps2_rx_if.sv
// Receiver-to-consumer handshake: received byte, done/error pulses and the enable back.
interface ps2_rx_if;
    logic       rx_en;
    logic [7:0] rx_data;
    logic       rx_done_tick;
    logic       frame_err;

    // Receiver side drives the byte and the pulses.
    modport master (
        input  rx_en,
        output rx_data,
        output rx_done_tick,
        output frame_err
    );

    // Consumer side (e.g. keyboard_ctl) drives the enable.
    modport slave (
        output rx_en,
        input  rx_data,
        input  rx_done_tick,
        input  frame_err
    );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: 2-FF synchronisers, ps2_clk deglitch filter,
// 11-bit frame deserialiser with odd-parity/stop check and mid-frame timeout.
module ps2_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     ps2_clk_i,
    input  logic     ps2_data_i,
    ps2_rx_if.master rx_if
);

    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic [1:0]      clk_sync_q;
    logic [1:0]      data_sync_q;
    logic            clk_s;
    logic            data_s;
    logic [7:0]      filt_cnt_q, filt_cnt_d;
    logic            filt_q, filt_d;
    logic            filt_prev_q;
    logic            fall;

    state_e          state_q;
    logic [2:0]      bit_cnt_q;
    logic [TmoW-1:0] tmo_q;
    logic [7:0]      shift_q;
    logic            parity_q;
    logic [7:0]      rx_data_q;
    logic            done_q;
    logic            err_q;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    // Both lines see the same two-stage delay so data stays aligned with clock edges.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
        end
    end

    // Filtered clock follows the synchronised clock only after FILTER_LEN equal samples.
    always_comb begin
        filt_cnt_d = 8'd0;
        filt_d     = filt_q;
        if (clk_s != filt_q) begin
            if (filt_cnt_q == 8'(FILTER_LEN - 1)) begin
                filt_d = clk_s;
            end else begin
                filt_cnt_d = filt_cnt_q + 8'd1;
            end
        end
    end

    // Filter state and the delayed copy used for edge detection.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            filt_cnt_q  <= 8'd0;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
        end else begin
            filt_cnt_q  <= filt_cnt_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
        end
    end

    assign fall = filt_prev_q & ~filt_q;

    // Frame FSM with timeout; done/error pulses are registered so they land one cycle after
    // the stop-bit edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            bit_cnt_q <= 3'd0;
            tmo_q     <= '0;
            shift_q   <= 8'h00;
            parity_q  <= 1'b0;
            rx_data_q <= 8'h00;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (state_q == StIdle) begin
                tmo_q <= '0;
                if (fall && rx_if.rx_en && !data_s) begin
                    state_q   <= StData;
                    bit_cnt_q <= 3'd0;
                end
            end else if (fall) begin
                tmo_q <= '0;
                unique case (state_q)
                    StData: begin
                        shift_q   <= {data_s, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= StParity;
                        end
                    end
                    StParity: begin
                        parity_q <= data_s;
                        state_q  <= StStop;
                    end
                    StStop: begin
                        // Odd parity: data bits plus parity bit must hold an odd count of ones.
                        if (data_s && ((^shift_q) ^ parity_q)) begin
                            rx_data_q <= shift_q;
                            done_q    <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                err_q   <= 1'b1;
                state_q <= StIdle;
                tmo_q   <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

    assign rx_if.rx_data      = rx_data_q;
    assign rx_if.rx_done_tick = done_q;
    assign rx_if.frame_err    = err_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: directed PS/2 frames, an expected-event queue with timing windows, and a
// per-cycle compare of pulses and rx_data against the bench's own view of the byte stream.
module tb_ps2_rx;

    localparam int unsigned Filt = 8;
    localparam int unsigned Tmo  = 200;
    localparam int unsigned Half = 40;  // scaled PS/2 half-period in clk cycles

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;

    ps2_rx_if rx_if ();

    ps2_rx #(
        .FILTER_LEN     (Filt),
        .TIMEOUT_CYCLES (Tmo)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .rx_if      (rx_if)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [7:0]  data;
        int unsigned lo;
        int unsigned hi;
    } exp_t;

    exp_t       expq[$];
    exp_t       cur;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] model_data = 8'h00;
    bit         chk_en = 1'b0;
    bit         key_left = 1'b0;
    bit         brk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Every cycle: pulses must match the queued expectation and rx_data must hold the last good byte.
    always @(negedge clk) begin
        if (chk_en) begin
            if (rx_if.rx_done_tick && rx_if.frame_err) check("tick_and_err", 32'd1, 32'd0);
            if (rx_if.rx_done_tick || rx_if.frame_err) begin
                if (expq.size() == 0) begin
                    check("unexpected_event", {30'd0, rx_if.rx_done_tick, rx_if.frame_err}, 32'd0);
                end else begin
                    cur = expq.pop_front();
                    check("event_kind", {31'd0, rx_if.frame_err}, {31'd0, cur.is_err});
                    check("event_window", {31'd0, (cyc >= cur.lo && cyc <= cur.hi)}, 32'd1);
                    if (!cur.is_err) model_data = cur.data;
                end
            end
            check("rx_data", {24'd0, rx_if.rx_data}, {24'd0, model_data});
            // Minimal keyboard consumer: F0 prefix marks the next code as a break.
            if (rx_if.rx_done_tick) begin
                if (rx_if.rx_data == 8'hF0) begin
                    brk = 1'b1;
                end else begin
                    if (rx_if.rx_data == 8'h1C) key_left = !brk;
                    brk = 1'b0;
                end
            end
        end
    end

    // kind: 0 none, 1 good byte, 2 frame error at stop, 3 timeout after the last bit sent.
    task automatic send_bits(input logic [10:0] bits, input int n, input int glitch_at,
                             input int kind);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if (i == glitch_at) begin
                wait_cyc(Half / 4);
                ps2_clk = 1'b0;
                wait_cyc(3);
                ps2_clk = 1'b1;
                wait_cyc(Half / 4 - 3);
            end else begin
                wait_cyc(Half / 2);
            end
            ps2_data = bits[i];
            wait_cyc(Half / 2);
            ps2_clk = 1'b0;
            if (i == n - 1 && kind != 0) begin
                e.is_err = (kind != 1);
                e.data   = bits[8:1];
                e.lo     = cyc + ((kind == 3) ? Tmo : Filt);
                e.hi     = cyc + ((kind == 3) ? Tmo + Filt + 8 : Filt + 6);
                expq.push_back(e);
            end
            wait_cyc(Half);
            ps2_clk = 1'b1;
        end
        wait_cyc(Half / 2);
        ps2_data = 1'b1;
        wait_cyc(Half / 2);
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input bit par_flip, input bit stop);
        return {stop, odd_par(b) ^ par_flip, b, 1'b0};
    endfunction

    task automatic drain();
        for (int i = 0; i < 4 * Tmo && expq.size() != 0; i++) wait_cyc(1);
        if (expq.size() != 0) begin
            check("missed_event", expq.size(), 32'd0);
            expq.delete();
        end
        wait_cyc(20);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        rx_if.rx_en = 1'b1;
        rst_n       = 1'b0;
        wait_cyc(3);
        check("reset_rx_data", {24'd0, rx_if.rx_data}, 32'h00);
        check("reset_tick", {31'd0, rx_if.rx_done_tick}, 32'd0);
        check("reset_err", {31'd0, rx_if.frame_err}, 32'd0);
        rst_n = 1'b1;
        wait_cyc(2);
        chk_en = 1'b1;

        // Hand-computed odd parity bits pin the model.
        check("par_1D", {31'd0, odd_par(8'h1D)}, 32'd1);
        check("par_23", {31'd0, odd_par(8'h23)}, 32'd0);
        check("par_F0", {31'd0, odd_par(8'hF0)}, 32'd1);
        check("frame_1C", {21'd0, frame(8'h1C, 1'b0, 1'b1)}, 32'h438);

        // Single valid frame.
        send_bits(frame(8'h1D, 1'b0, 1'b1), 11, -1, 1);
        drain();
        check("byte_1D", {24'd0, rx_if.rx_data}, 32'h1D);

        // Make then break of 0x1C.
        send_bits(frame(8'h1C, 1'b0, 1'b1), 11, -1, 1);
        drain();
        check("key_left_make", {31'd0, key_left}, 32'd1);
        send_bits(frame(8'hF0, 1'b0, 1'b1), 11, -1, 1);
        send_bits(frame(8'h1C, 1'b0, 1'b1), 11, -1, 1);
        drain();
        check("byte_1C_break", {24'd0, rx_if.rx_data}, 32'h1C);
        check("key_left_break", {31'd0, key_left}, 32'd0);

        // Parity error, then stop-bit error; rx_data must hold 0x1C.
        send_bits(frame(8'h23, 1'b1, 1'b1), 11, -1, 2);
        drain();
        check("hold_after_par_err", {24'd0, rx_if.rx_data}, 32'h1C);
        send_bits(frame(8'h23, 1'b0, 1'b0), 11, -1, 2);
        drain();
        check("hold_after_stop_err", {24'd0, rx_if.rx_data}, 32'h1C);

        // Stall after start + 5 data bits, then recover with a good frame.
        send_bits(frame(8'h23, 1'b0, 1'b1), 6, -1, 3);
        drain();
        send_bits(frame(8'h1D, 1'b0, 1'b1), 11, -1, 1);
        drain();
        check("byte_1D_after_tmo", {24'd0, rx_if.rx_data}, 32'h1D);

        // Short glitches while idle and mid-frame must not create edges.
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(50);
        send_bits(frame(8'h1C, 1'b0, 1'b1), 11, 4, 1);
        drain();
        check("byte_1C_glitch", {24'd0, rx_if.rx_data}, 32'h1C);

        // Reset after the 4th data bit; the partial frame must vanish silently.
        send_bits(frame(8'h1D, 1'b0, 1'b1), 5, -1, 0);
        chk_en = 1'b0;
        rst_n  = 1'b0;
        wait_cyc(2);
        rst_n      = 1'b1;
        model_data = 8'h00;
        chk_en     = 1'b1;
        check("rx_data_after_rst", {24'd0, rx_if.rx_data}, 32'h00);
        wait_cyc(Tmo + 50);
        send_bits(frame(8'h1D, 1'b0, 1'b1), 11, -1, 1);
        drain();
        check("byte_1D_after_rst", {24'd0, rx_if.rx_data}, 32'h1D);

        // Disabled receiver ignores a whole frame.
        rx_if.rx_en = 1'b0;
        send_bits(frame(8'h1C, 1'b0, 1'b1), 11, -1, 0);
        wait_cyc(Tmo + 50);
        rx_if.rx_en = 1'b1;
        check("hold_rx_en_off", {24'd0, rx_if.rx_data}, 32'h1D);
        check("queue_empty", expq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
